simple_reset_sequencer: RTL

SIMPLE_RESET_SEQUENCER -- requirements
Module: simple_reset_sequencer

---
 rtl/simple_reset_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/simple_reset_sequencer.sv
// ----------------------------------------------------------------------------
// simple_reset_sequencer
//
// Releases the four sbus clock-group member resets one at a time, in order
// 0..3, with STAGGER_CYCLES clock cycles between successive releases. The
// sequence starts after the asynchronous system reset has been deasserted
// and its release has been synchronized. Software can re-run the whole
// sequence from DONE.
//
// Parameters
//   SYNC_STAGES     depth of the reset-deassertion synchronizer (2..4)
//   STAGGER_CYCLES  cycles between member releases (1..255)
//
// Ports
//   clock                               single clock for all logic
//   reset                               asynchronous reset, active low
//   sw_reset_req                        request to re-run the sequence;
//                                       honoured only in DONE
//   out_member_subsystem_sbus_N_reset   active-high member resets, N = 0..3
//   seq_done                            all four member resets released
//   seq_state                           FSM state (HOLD=0, STAGGER=1,
//                                       DONE=2, REASSERT=3)
//
// Handshake: sw_reset_req is a level sampled on the rising clock edge. It is
// acted on only when sampled high while in DONE; in any other state it is
// dropped, never queued. There is no acknowledge beyond seq_state/seq_done.
// ----------------------------------------------------------------------------
module simple_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sw_reset_req,
    output logic       out_member_subsystem_sbus_0_reset,
    output logic       out_member_subsystem_sbus_1_reset,
    output logic       out_member_subsystem_sbus_2_reset,
    output logic       out_member_subsystem_sbus_3_reset,
    output logic       seq_done,
    output logic [1:0] seq_state
);

    localparam logic [1:0] ST_HOLD     = 2'd0;
    localparam logic [1:0] ST_STAGGER  = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;
    localparam logic [1:0] ST_REASSERT = 2'd3;

    // Terminal count; STAGGER_CYCLES <= 255 so this never needs a 9th bit.
    localparam logic [7:0] CNT_LAST = 8'(STAGGER_CYCLES - 1);

    // ------------------------------------------------------------------
    // Reset-deassertion synchronizer: clears asynchronously, shifts in 1.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   rst_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_chain[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [1:0] state,      state_nxt;
    logic [7:0] count,      count_nxt;
    logic [1:0] member_idx, member_idx_nxt;
    logic [3:0] member_rst, member_rst_nxt;
    logic       done_q,     done_nxt;
    logic       count_last;

    assign count_last = (count == CNT_LAST);

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        member_idx_nxt = member_idx;
        member_rst_nxt = member_rst;
        done_nxt       = done_q;

        case (state)
            ST_HOLD: begin
                member_rst_nxt = 4'hF;
                done_nxt       = 1'b0;
                member_idx_nxt = 2'd0;
                count_nxt      = 8'd0;
                if (rst_sync) begin
                    state_nxt = ST_STAGGER;
                    // The edge that leaves HOLD is the first cycle of the
                    // member-0 stagger interval. With STAGGER_CYCLES=1 that
                    // interval is already complete, so member 0 is released
                    // here and the remaining members follow on consecutive
                    // edges with no idle cycle.
                    if (count_last) begin
                        member_rst_nxt[0] = 1'b0;
                        member_idx_nxt    = 2'd1;
                    end else begin
                        count_nxt = 8'd1;
                    end
                end
            end

            ST_STAGGER: begin
                if (count_last) begin
                    count_nxt                  = 8'd0;
                    // Released members keep their 0 because member_rst_nxt
                    // defaults to the current register value.
                    member_rst_nxt[member_idx] = 1'b0;
                    member_idx_nxt             = member_idx + 2'd1;
                    if (member_idx == 2'd3) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count + 8'd1;
                end
            end

            ST_DONE: begin
                if (sw_reset_req) begin
                    member_rst_nxt = 4'hF;
                    done_nxt       = 1'b0;
                    member_idx_nxt = 2'd0;
                    count_nxt      = 8'd0;
                    state_nxt      = ST_REASSERT;
                end
            end

            ST_REASSERT: begin
                // Hold every member in reset for a full stagger interval,
                // then start a fresh stagger from member 0.
                if (count_last) begin
                    count_nxt = 8'd0;
                    state_nxt = ST_STAGGER;
                end else begin
                    count_nxt = count + 8'd1;
                end
            end

            default: begin
                state_nxt = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_HOLD;
            count      <= 8'd0;
            member_idx <= 2'd0;
            member_rst <= 4'hF;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            member_idx <= member_idx_nxt;
            member_rst <= member_rst_nxt;
            done_q     <= done_nxt;
        end
    end

    // Every output comes straight from a flop.
    assign out_member_subsystem_sbus_0_reset = member_rst[0];
    assign out_member_subsystem_sbus_1_reset = member_rst[1];
    assign out_member_subsystem_sbus_2_reset = member_rst[2];
    assign out_member_subsystem_sbus_3_reset = member_rst[3];
    assign seq_done                          = done_q;
    assign seq_state                         = state;

endmodule
